sprite_line_scanner: RTL and testbench

Parametrised per-scanline sprite evaluator with a double-buffered output list. On a `start` pulse it scans all OAM entries once and selects the sprites that intersect `line_y`. It writes up to `MAX_PER_LINE` entries, each holding an OAM index and a y-flip-corrected sprite row, into a back bank, while the renderer reads the front bank. It sits between OAM RAM and the sprite fetch/render stage and replaces per-line preparation driven by change detection.

---
 rtl/sprite_line_scanner_if.sv | 34 +++
 rtl/sprite_line_scanner.sv | 207 ++++++++++++++++++++
 tb/tb_sprite_line_scanner.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_line_scanner_if.sv
// Port bundle for sprite_line_scanner: scan control, OAM read port and front-bank list read port.
// The slave modport is the scanner itself; the master modport is its surrounding system.
interface sprite_line_scanner_if #(
    parameter int MAX_PER_LINE = 32,
    parameter int OAM_ADDR_W   = 8,
    parameter int COORD_W      = 10
);
    localparam int IDX_W = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
    localparam int CNT_W = $clog2(MAX_PER_LINE + 1);

    logic                    start;
    logic [COORD_W-1:0]      line_y;
    logic [1:0]              height_mode;
    logic                    swap;
    logic [OAM_ADDR_W-1:0]   oam_addr;
    logic                    oam_rd_en;
    logic [31:0]             oam_data;
    logic [IDX_W-1:0]        rd_index;
    logic [OAM_ADDR_W+5:0]   rd_entry;
    logic [CNT_W-1:0]        rd_count;
    logic                    busy;
    logic                    done;
    logic                    overflow;

    modport master (
        output start, line_y, height_mode, swap, oam_data, rd_index,
        input  oam_addr, oam_rd_en, rd_entry, rd_count, busy, done, overflow
    );

    modport slave (
        input  start, line_y, height_mode, swap, oam_data, rd_index,
        output oam_addr, oam_rd_en, rd_entry, rd_count, busy, done, overflow
    );
endinterface

// File: rtl/sprite_line_scanner.sv
// Per-scanline sprite evaluator: walks OAM once per start pulse and builds a list of sprites
// that cover line_y in the back bank, while the renderer reads the front bank.
module sprite_line_scanner #(
    parameter int MAX_PER_LINE = 32,
    parameter int OAM_OBJECTS  = 256,
    parameter int OAM_ADDR_W   = 8,
    parameter int COORD_W      = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    sprite_line_scanner_if.slave bus
);
    localparam int IDX_W  = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
    localparam int CNT_W  = $clog2(MAX_PER_LINE + 1);
    localparam int DATA_W = OAM_ADDR_W + 5;

    localparam logic [OAM_ADDR_W-1:0] LAST_ADDR = OAM_ADDR_W'(OAM_OBJECTS - 1);
    localparam logic [CNT_W-1:0]      FULL      = CNT_W'(MAX_PER_LINE);
    localparam logic [COORD_W:0]      ONE       = {{COORD_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [OAM_ADDR_W-1:0]   r_addr;
    logic [OAM_ADDR_W-1:0]   r_pendIdx;
    logic                    r_pendValid;
    logic                    r_done;
    logic                    r_front;
    logic                    r_swapPending;
    logic [COORD_W-1:0]      r_lineY;
    logic [5:0]              r_height;
    logic [CNT_W-1:0]        r_count   [2];
    logic                    r_ovf     [2];
    logic [MAX_PER_LINE-1:0] r_valid   [2];
    logic [DATA_W-1:0]       r_entries [2][MAX_PER_LINE];

    logic                    w_rdEn;
    logic                    w_busy;
    logic                    w_finish;
    logic                    w_lastAddr;
    logic                    w_doSwap;
    logic                    w_back;
    logic                    w_newBack;
    logic [5:0]              w_heightSel;
    logic [COORD_W:0]        w_ypos;
    logic [COORD_W:0]        w_lineExt;
    logic [COORD_W:0]        w_heightExt;
    logic [COORD_W:0]        w_diff;
    logic [COORD_W:0]        w_rowFull;
    logic [4:0]              w_row;
    logic                    w_hit;
    logic                    w_accept;
    logic                    w_write;
    logic                    w_rdHit;
    logic                    w_unusedBits;

    assign w_lastAddr = (r_addr == LAST_ADDR);

    // State register for the scan sequencer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A start pulse in any state (re)launches the scan from address 0.
    always_comb begin
        w_nextState = r_state;
        w_rdEn      = 1'b0;
        w_busy      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_nextState = SCAN;
                end
            end
            SCAN: begin
                w_rdEn = 1'b1;
                w_busy = 1'b1;
                if (bus.start) begin
                    w_nextState = SCAN;
                end else if (w_lastAddr) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                w_busy = 1'b1;
                if (bus.start) begin
                    w_nextState = SCAN;
                end else begin
                    w_nextState = IDLE;
                    w_finish    = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_comb begin
        w_heightSel = 6'd16;
        case (bus.height_mode)
            2'd0:    w_heightSel = 6'd8;
            2'd2:    w_heightSel = 6'd32;
            default: w_heightSel = 6'd16;
        endcase
    end

    // Swaps only happen while idle; the done cycle is idle, which is where a deferred swap lands.
    assign w_doSwap  = (r_state == IDLE) && (bus.swap || r_swapPending);
    assign w_back    = ~r_front;
    assign w_newBack = w_doSwap ? r_front : ~r_front;

    // One extra bit keeps line_y < ypos from wrapping into a small positive difference.
    assign w_ypos      = (COORD_W + 1)'(bus.oam_data[27:18]);
    assign w_lineExt   = {1'b0, r_lineY};
    assign w_heightExt = (COORD_W + 1)'(r_height);
    assign w_diff      = w_lineExt - w_ypos;
    assign w_hit       = bus.oam_data[31] && (w_lineExt >= w_ypos) && (w_diff < w_heightExt);
    assign w_rowFull   = bus.oam_data[30] ? (w_heightExt - ONE - w_diff) : w_diff;
    assign w_row       = w_rowFull[4:0];

    assign w_accept = r_pendValid && w_hit && !bus.start;
    assign w_write  = w_accept && (r_count[w_back] != FULL);

    assign w_unusedBits = ^{bus.oam_data[29:28], bus.oam_data[17:0], w_rowFull[COORD_W:5]};

    // Scan bookkeeping and list bank state; a start clears whichever bank becomes the back bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr        <= '0;
            r_pendIdx     <= '0;
            r_pendValid   <= 1'b0;
            r_done        <= 1'b0;
            r_front       <= 1'b0;
            r_swapPending <= 1'b0;
            r_lineY       <= '0;
            r_height      <= 6'd8;
            r_count[0]    <= '0;
            r_count[1]    <= '0;
            r_ovf[0]      <= 1'b0;
            r_ovf[1]      <= 1'b0;
            r_valid[0]    <= '0;
            r_valid[1]    <= '0;
        end else begin
            r_done      <= w_finish;
            r_pendValid <= w_rdEn && !bus.start;
            r_pendIdx   <= r_addr;

            if (bus.start) begin
                r_addr <= '0;
            end else if (r_state == SCAN) begin
                r_addr <= w_lastAddr ? '0 : r_addr + 1'b1;
            end

            if (w_doSwap) begin
                r_front       <= ~r_front;
                r_swapPending <= 1'b0;
            end else if (bus.swap && w_busy) begin
                r_swapPending <= 1'b1;
            end

            if (bus.start) begin
                r_lineY            <= bus.line_y;
                r_height           <= w_heightSel;
                r_count[w_newBack] <= '0;
                r_ovf[w_newBack]   <= 1'b0;
                r_valid[w_newBack] <= '0;
            end else if (w_accept) begin
                if (w_write) begin
                    r_count[w_back]                            <= r_count[w_back] + 1'b1;
                    r_valid[w_back][IDX_W'(r_count[w_back])] <= 1'b1;
                end else begin
                    r_ovf[w_back] <= 1'b1;
                end
            end
        end
    end

    // Entry payload storage needs no reset: reads are gated by the valid count.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_entries[w_back][IDX_W'(r_count[w_back])] <= {w_row, r_pendIdx};
        end
    end

    assign w_rdHit = (CNT_W'(bus.rd_index) < r_count[r_front]);

    assign bus.rd_entry  = w_rdHit ? {r_valid[r_front][bus.rd_index], r_entries[r_front][bus.rd_index]}
                                   : '0;
    assign bus.rd_count  = r_count[r_front];
    assign bus.overflow  = r_ovf[r_front];
    assign bus.oam_addr  = r_addr;
    assign bus.oam_rd_en = w_rdEn;
    assign bus.busy      = w_busy;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_sprite_line_scanner.sv
// Directed bench for sprite_line_scanner: a behavioural OAM answers reads one cycle late, and
// each scenario checks list contents, bank swapping and scan timing against hand-worked values.
module tb_sprite_line_scanner;
    localparam int MAXL = 32;
    localparam int NOBJ = 256;
    localparam int AW   = 8;
    localparam int CW   = 10;

    logic        clk = 1'b0;
    logic        reset;
    int          vectors = 0;
    int          miscompares = 0;
    int          doneCount = 0;
    int          n;
    int          d0;
    logic [31:0] oam [NOBJ];

    sprite_line_scanner_if #(.MAX_PER_LINE(MAXL), .OAM_ADDR_W(AW), .COORD_W(CW)) bus ();

    sprite_line_scanner #(
        .MAX_PER_LINE(MAXL),
        .OAM_OBJECTS (NOBJ),
        .OAM_ADDR_W  (AW),
        .COORD_W     (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.oam_rd_en) begin
            bus.oam_data <= oam[bus.oam_addr];
        end
    end

    always @(posedge clk) begin
        if (bus.done) begin
            doneCount++;
        end
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one cycle of control inputs; returns at the falling edge of the cycle after the sampling edge.
    task automatic applyStimulus(input logic doStart, input logic doSwap, input logic [9:0] line,
                                 input logic [1:0] hm);
        @(negedge clk);
        bus.start       = doStart;
        bus.swap        = doSwap;
        bus.line_y      = line;
        bus.height_mode = hm;
        @(negedge clk);
        bus.start = 1'b0;
        bus.swap  = 1'b0;
    endtask

    task automatic waitDone(input int startN, output int cyc);
        cyc = startN;
        while (!bus.done && cyc < 600) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic checkEntry(input string tag, input logic [4:0] idx, input logic [31:0] expected);
        bus.rd_index = idx;
        #1;
        checkOutput(tag, 32'(bus.rd_entry), expected);
    endtask

    task automatic scanAndSwap(input logic [9:0] line, input logic [1:0] hm);
        int cyc;
        applyStimulus(1'b1, 1'b0, line, hm);
        waitDone(1, cyc);
        checkOutput("scanLatency", 32'(cyc), 32'd258);
        applyStimulus(1'b0, 1'b1, line, hm);
    endtask

    function automatic logic [31:0] mkSprite(input logic en, input logic yflip, input logic [9:0] ypos);
        return {en, yflip, 2'b00, ypos, 18'd0};
    endfunction

    task automatic clearOam();
        for (int i = 0; i < NOBJ; i++) begin
            oam[i] = 32'd0;
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.swap        = 1'b0;
        bus.line_y      = '0;
        bus.height_mode = '0;
        bus.rd_index    = '0;
        clearOam();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        checkOutput("rstBusy", 32'(bus.busy), 32'd0);
        checkOutput("rstDone", 32'(bus.done), 32'd0);
        checkOutput("rstOverflow", 32'(bus.overflow), 32'd0);
        checkOutput("rstCount", 32'(bus.rd_count), 32'd0);
        checkOutput("rstRdEn", 32'(bus.oam_rd_en), 32'd0);
        checkOutput("rstAddr", 32'(bus.oam_addr), 32'd0);
        checkEntry("rstEntry0", 5'd0, 32'd0);

        // Basic hit selection with yflip and a disabled sprite.
        oam[5]  = mkSprite(1'b1, 1'b0, 10'd100);
        oam[9]  = mkSprite(1'b1, 1'b1, 10'd95);
        oam[12] = mkSprite(1'b0, 1'b0, 10'd100);
        applyStimulus(1'b1, 1'b0, 10'd100, 2'd1);
        checkOutput("busyT1", 32'(bus.busy), 32'd1);
        checkOutput("rdEnT1", 32'(bus.oam_rd_en), 32'd1);
        checkOutput("addrT1", 32'(bus.oam_addr), 32'd0);
        waitDone(1, n);
        checkOutput("doneLatency", 32'(n), 32'd258);
        checkOutput("busyAtDone", 32'(bus.busy), 32'd0);
        checkOutput("rdEnAtDone", 32'(bus.oam_rd_en), 32'd0);
        checkOutput("countBeforeSwap", 32'(bus.rd_count), 32'd0);
        applyStimulus(1'b0, 1'b1, 10'd100, 2'd1);
        checkOutput("basicCount", 32'(bus.rd_count), 32'd2);
        checkOutput("basicOverflow", 32'(bus.overflow), 32'd0);
        checkEntry("basicEntry0", 5'd0, 32'h2005);
        checkEntry("basicEntry1", 5'd1, 32'h2A09);
        checkEntry("basicEntry2", 5'd2, 32'd0);

        // 40 sprites on the same rows: the list caps at 32 and flags overflow.
        clearOam();
        for (int i = 0; i < 40; i++) begin
            oam[i] = mkSprite(1'b1, 1'b0, 10'd50);
        end
        scanAndSwap(10'd55, 2'd0);
        checkOutput("ovf55Count", 32'(bus.rd_count), 32'd32);
        checkOutput("ovf55Flag", 32'(bus.overflow), 32'd1);
        checkEntry("ovf55Entry0", 5'd0, 32'h2500);
        checkEntry("ovf55Entry31", 5'd31, 32'h251F);
        scanAndSwap(10'd57, 2'd0);
        checkOutput("ovf57Count", 32'(bus.rd_count), 32'd32);
        checkEntry("ovf57Entry31", 5'd31, 32'h271F);

        // Scan H=32 into the back bank, then start+swap shows it while rescanning the old front.
        applyStimulus(1'b1, 1'b0, 10'd81, 2'd2);
        waitDone(1, n);
        checkOutput("h32Latency", 32'(n), 32'd258);
        applyStimulus(1'b1, 1'b1, 10'd58, 2'd0);
        checkOutput("startSwapCount", 32'(bus.rd_count), 32'd32);
        checkOutput("startSwapOvf", 32'(bus.overflow), 32'd1);
        checkEntry("startSwapEntry0", 5'd0, 32'h3F00);
        checkEntry("startSwapEntry31", 5'd31, 32'h3F1F);
        waitDone(1, n);
        checkOutput("line58Latency", 32'(n), 32'd258);
        applyStimulus(1'b0, 1'b1, 10'd58, 2'd0);
        checkOutput("line58Count", 32'(bus.rd_count), 32'd0);
        checkOutput("line58Ovf", 32'(bus.overflow), 32'd0);
        checkEntry("line58Entry0", 5'd0, 32'd0);
        applyStimulus(1'b0, 1'b1, 10'd58, 2'd0);
        checkOutput("swapBackCount", 32'(bus.rd_count), 32'd32);
        checkEntry("swapBackEntry0", 5'd0, 32'h3F00);

        // Swap requested mid-scan is deferred to the done cycle.
        applyStimulus(1'b1, 1'b0, 10'd56, 2'd0);
        n = 1;
        repeat (48) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        n++;
        bus.swap = 1'b1;
        @(negedge clk);
        n++;
        bus.swap = 1'b0;
        while (n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("heldCount", 32'(bus.rd_count), 32'd32);
        checkEntry("heldEntry0", 5'd0, 32'h3F00);
        waitDone(n, n);
        checkOutput("deferLatency", 32'(n), 32'd258);
        checkEntry("deferAtDone", 5'd0, 32'h3F00);
        @(negedge clk);
        checkEntry("deferAfterDone", 5'd0, 32'h2600);
        checkOutput("deferCount", 32'(bus.rd_count), 32'd32);
        checkOutput("deferOvf", 32'(bus.overflow), 32'd1);

        // A second start at T+100 aborts the first scan.
        clearOam();
        oam[3] = mkSprite(1'b1, 1'b0, 10'd200);
        oam[7] = mkSprite(1'b1, 1'b0, 10'd300);
        d0 = doneCount;
        applyStimulus(1'b1, 1'b0, 10'd200, 2'd1);
        repeat (98) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 10'd300, 2'd1);
        waitDone(1, n);
        checkOutput("abortLatency", 32'(n), 32'd258);
        applyStimulus(1'b0, 1'b1, 10'd300, 2'd1);
        checkOutput("abortDonePulses", 32'(doneCount - d0), 32'd1);
        checkOutput("abortCount", 32'(bus.rd_count), 32'd1);
        checkEntry("abortEntry0", 5'd0, 32'h2007);

        // Coordinate boundaries: ypos 1023 never wraps, ypos 0 reaches row 15.
        clearOam();
        oam[0] = mkSprite(1'b1, 1'b0, 10'd1023);
        oam[1] = mkSprite(1'b1, 1'b0, 10'd0);
        oam[2] = mkSprite(1'b1, 1'b1, 10'd0);
        scanAndSwap(10'd0, 2'd1);
        checkOutput("line0Count", 32'(bus.rd_count), 32'd2);
        checkEntry("line0Entry0", 5'd0, 32'h2001);
        checkEntry("line0Entry1", 5'd1, 32'h2F02);
        scanAndSwap(10'd15, 2'd1);
        checkOutput("line15Count", 32'(bus.rd_count), 32'd2);
        checkEntry("line15Entry0", 5'd0, 32'h2F01);
        checkEntry("line15Entry1", 5'd1, 32'h2002);

        // Reset in the middle of a scan empties both banks and suppresses done.
        applyStimulus(1'b1, 1'b0, 10'd15, 2'd1);
        repeat (19) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midRstBusy", 32'(bus.busy), 32'd0);
        checkOutput("midRstRdEn", 32'(bus.oam_rd_en), 32'd0);
        checkOutput("midRstCount", 32'(bus.rd_count), 32'd0);
        checkOutput("midRstOvf", 32'(bus.overflow), 32'd0);
        checkEntry("midRstEntry0", 5'd0, 32'd0);
        d0 = doneCount;
        @(negedge clk);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        checkOutput("midRstNoDone", 32'(doneCount - d0), 32'd0);
        applyStimulus(1'b0, 1'b1, 10'd15, 2'd1);
        checkOutput("midRstOtherCount", 32'(bus.rd_count), 32'd0);
        checkEntry("midRstOtherEntry0", 5'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
